regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the single-cycle core's integer register file.
- Generalises width, depth and read-port count; x0 is hardwired to zero.
- Adds an optional write-to-read bypass, a post-reset clear sequencer that zeroes the array without an async-reset memory, and a registered debug read port with a req/ack handshake.
- Sits between decode and execute in the RISCV top; the debug port feeds the bench and a future debug module.

Parameters:
- XLEN, 32, data width in bits.
- NUM_REGS, 32, number of architectural registers; min 2, need not be a power of 2.
- NUM_RD, 2, number of combinational read ports; min 1.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads.
- CLEAR_ON_RESET, 1, 1 = run the clear sequencer after reset release.
- AW (localparam), $clog2(NUM_REGS), address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- rd_addr  in  NUM_RD*AW  packed read addresses; port i = bits [i*AW +: AW].
- rd_data  out  NUM_RD*XLEN  packed read data; port i = bits [i*XLEN +: XLEN].
- we  in  1  write enable.
- wr_addr  in  AW  write address.
- wr_data  in  XLEN  write data.
- init_busy  out  1  high while the clear sequencer runs.
- dbg_req  in  1  debug read request, single-cycle pulse or level.
- dbg_addr  in  AW  debug read address.
- dbg_ack  out  1  one-cycle pulse, debug data valid.
- dbg_data  out  XLEN  registered debug read data.

Behaviour:
- State machine: two states, CLEAR and RUN.
  - reset=0 forces, asynchronously: state=CLEAR (RUN if CLEAR_ON_RESET=0), clr_cnt=1, dbg_ack=0, dbg_data=0.
  - Array contents are not reset.
- CLEAR state:
  - Each clk writes 0 to mem[clr_cnt], then clr_cnt++.
  - After writing index NUM_REGS-1, the next state is RUN.
  - init_busy=1 throughout CLEAR: exactly NUM_REGS-1 cycles after reset release (31 at defaults).
  - init_busy=0 in RUN and always 0 when CLEAR_ON_RESET=0.
  - In CLEAR, we is ignored, dbg_req is ignored (no ack, no queueing), and all rd_data read 0.
- Reads (combinational, every port independent):
  - Return 0 if addr==0 or addr>=NUM_REGS.
  - Otherwise, if BYPASS=1, state=RUN, we=1 and wr_addr==addr, return wr_data.
  - Otherwise return mem[addr].
- Writes:
  - On posedge clk, if state=RUN, we=1, wr_addr!=0 and wr_addr<NUM_REGS, then mem[wr_addr]<=wr_data.
  - All other writes are silently dropped.
  - The new value is visible on reads from the next cycle (same cycle only when BYPASS=1).
- Debug port:
  - When dbg_req=1 in RUN, the next posedge sets dbg_ack=1 and latches dbg_data with the same value read-port logic would return for dbg_addr in the request cycle, bypass included.
  - Latency is 1 cycle; dbg_ack falls the following cycle unless dbg_req is still high, so a held req gives back-to-back acks, one per cycle.
  - dbg_data holds its value between acks.
- Reset mid-operation:
  - Asserting reset during CLEAR or RUN aborts immediately.
  - On release, clearing restarts from index 1 and takes the full NUM_REGS-1 cycles.
  - A pending dbg_ack is dropped.
- Simultaneous events:
  - A write and a read to the same address in one cycle: the read follows the bypass rule above.
  - A write and a dbg_req to the same address in one cycle: dbg_data follows the same bypass rule.
  - Multiple read ports on the same address return identical data.

Test Plan:
1. Defaults; release reset at t=20ns -> init_busy=1 for exactly 31 clk cycles; then rd_data on both ports reads 0 for all addresses 0..31.
2. RUN; we=1, wr_addr=5, wr_data=0xDEADBEEF, rd_addr0=5 same cycle -> rd_data0=0xDEADBEEF the same cycle; next cycle with we=0, rd_addr1=5 -> rd_data1=0xDEADBEEF. Repeat with BYPASS=0 -> same-cycle read returns 0.
3. we=1, wr_addr=0, wr_data=0x00001234 -> x0 reads 0 on every port and on the debug port.
4. we=1, wr_addr=7, wr_data=0xA5A5A5A5 while init_busy=1 -> after init, x7 reads 0; dbg_req during init -> dbg_ack stays 0.
5. dbg_req=1 with dbg_addr=5 for one cycle after scenario 2 -> dbg_ack=1 on the next cycle only, dbg_data=0xDEADBEEF and held after ack falls.
6. Assert reset 10 cycles into CLEAR, release -> init_busy restarts at full 31 cycles. Separately, NUM_RD=3, NUM_REGS=24: writes to 20 are stored, writes to 25 are dropped, reads of 25 return 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Parametrised integer register file: x0 hardwired to zero, optional write
// bypass, post-reset clear sequencer and a registered req/ack debug port.
module regfile_mp #(
  parameter int XLEN           = 32,
  parameter int NUM_REGS       = 32,
  parameter int NUM_RD         = 2,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW            = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  input  logic                   we,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  output logic                   init_busy,
  input  logic                   dbg_req,
  input  logic [AW-1:0]          dbg_addr,
  output logic                   dbg_ack,
  output logic [XLEN-1:0]        dbg_data
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]      state;
  logic [AW-1:0]   clr_cnt;
  logic [XLEN-1:0] mem [NUM_REGS];
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [XLEN-1:0] mem_wd;
  logic [XLEN-1:0] dbg_val;
  logic            wr_ok;

  assign init_busy = (state == CLEAR);
  assign wr_ok = (state == RUN) && we && (wr_addr != '0)
              && (32'(wr_addr) < NUM_REGS);

  function automatic logic [XLEN-1:0] rd_val(
    input logic [AW-1:0] a
  );
    logic [XLEN-1:0] v;
    v = '0;
    if (state == RUN && a != '0 && 32'(a) < NUM_REGS) begin
      if (BYPASS != 0 && we && wr_addr == a)
        v = wr_data;
      else
        v = mem[a];
    end
    return v;
  endfunction

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++)
      rd_data[i*XLEN +: XLEN] = rd_val(rd_addr[i*AW +: AW]);
    dbg_val = rd_val(dbg_addr);
  end

  // The clear sequencer shares the single array write port
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wr_addr;
    mem_wd = wr_data;
    if (state == CLEAR) begin
      mem_we = 1'b1;
      mem_wa = clr_cnt;
      mem_wd = '0;
    end else if (wr_ok) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_cnt  <= AW'(1);
      dbg_ack  <= 1'b0;
      dbg_data <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + AW'(1);
          dbg_ack <= 1'b0;
          if (32'(clr_cnt) == NUM_REGS - 1)
            state <= RUN;
        end
        default: begin
          dbg_ack <= dbg_req;
          if (dbg_req)
            dbg_data <= dbg_val;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default, no-bypass, small/3-port and
// no-clear instances driven from one linear sequence with a scoreboard.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        dbg_req;
  logic [4:0]  dbg_addr;

  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        init_busy;
  logic        dbg_ack;
  logic [31:0] dbg_data;

  logic [9:0]  nb_rd_addr;
  logic [63:0] nb_rd_data;
  logic        nb_busy;
  logic        nb_ack;
  logic [31:0] nb_dbg_data;

  logic        sm_we;
  logic [4:0]  sm_wr_addr;
  logic [14:0] sm_rd_addr;
  logic [95:0] sm_rd_data;
  logic        sm_busy;
  logic        sm_dbg_req;
  logic        sm_ack;
  logic [31:0] sm_dbg_data;

  logic [63:0] nc_rd_data;
  logic        nc_busy;
  logic        nc_ack;
  logic [31:0] nc_dbg_data;

  int checks = 0;
  int errors = 0;
  int n;
  int n_sm;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  regfile_mp u_dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_busy(init_busy),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_ack(dbg_ack), .dbg_data(dbg_data)
  );

  regfile_mp #(.BYPASS(0)) u_nb (
    .clk(clk), .reset(reset),
    .rd_addr(nb_rd_addr), .rd_data(nb_rd_data),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_busy(nb_busy),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_ack(nb_ack), .dbg_data(nb_dbg_data)
  );

  regfile_mp #(.NUM_REGS(24), .NUM_RD(3)) u_sm (
    .clk(clk), .reset(reset),
    .rd_addr(sm_rd_addr), .rd_data(sm_rd_data),
    .we(sm_we), .wr_addr(sm_wr_addr), .wr_data(wr_data),
    .init_busy(sm_busy),
    .dbg_req(sm_dbg_req), .dbg_addr(sm_wr_addr),
    .dbg_ack(sm_ack), .dbg_data(sm_dbg_data)
  );

  regfile_mp #(.CLEAR_ON_RESET(0)) u_nc (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(nc_rd_data),
    .we(1'b0), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_busy(nc_busy),
    .dbg_req(1'b0), .dbg_addr(dbg_addr),
    .dbg_ack(nc_ack), .dbg_data(nc_dbg_data)
  );

  task automatic push(input logic [31:0] e);
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic count_init(output int c, output int c_sm);
    c = 0;
    c_sm = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      c++;
      if (!sm_busy && c_sm == 0) c_sm = c;
      if (!init_busy) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0;
    dbg_req = 1'b0; dbg_addr = '0; rd_addr = '0;
    nb_rd_addr = '0; sm_we = 1'b0; sm_wr_addr = '0;
    sm_rd_addr = '0; sm_dbg_req = 1'b0;

    #20 reset = 1'b1;
    #1;
    push(1); chk("busy_after_release", 32'(init_busy));
    push(0); chk("nc_busy", 32'(nc_busy));
    push(0); chk("reset_ack", 32'(dbg_ack));
    push(0); chk("reset_dbg_data", dbg_data);

    count_init(n, n_sm);
    push(31); chk("init_cycles", n);
    push(23); chk("sm_init_cycles", n_sm);

    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a)};
      #1;
      push(0); chk("clear_p0", rd_data[31:0]);
      push(0); chk("clear_p1", rd_data[63:32]);
    end
    tick();

    // same-cycle write/read, bypass vs no bypass
    we = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    rd_addr = {5'd0, 5'd5}; nb_rd_addr = {5'd0, 5'd5};
    #1;
    push(32'hDEADBEEF); chk("bypass_p0", rd_data[31:0]);
    push(0); chk("nobypass_p0", nb_rd_data[31:0]);
    tick();
    we = 1'b0;
    rd_addr = {5'd5, 5'd0}; nb_rd_addr = {5'd5, 5'd0};
    #1;
    push(32'hDEADBEEF); chk("next_p1", rd_data[63:32]);
    push(32'hDEADBEEF); chk("nb_next_p1", nb_rd_data[63:32]);

    // x0 write dropped
    tick();
    we = 1'b1; wr_addr = 0; wr_data = 32'h00001234;
    rd_addr = '0; dbg_req = 1'b1; dbg_addr = 0;
    #1;
    push(0); chk("x0_p0", rd_data[31:0]);
    push(0); chk("x0_p1", rd_data[63:32]);
    tick();
    we = 1'b0; dbg_req = 1'b0;
    push(1); chk("x0_dbg_ack", 32'(dbg_ack));
    push(0); chk("x0_dbg_data", dbg_data);
    push(0); chk("x0_p0_after", rd_data[31:0]);

    // single debug pulse
    dbg_req = 1'b1; dbg_addr = 5;
    tick();
    dbg_req = 1'b0;
    push(1); chk("dbg_ack", 32'(dbg_ack));
    push(32'hDEADBEEF); chk("dbg_data", dbg_data);
    tick();
    push(0); chk("dbg_ack_fall", 32'(dbg_ack));
    push(32'hDEADBEEF); chk("dbg_data_hold", dbg_data);

    // held request gives back-to-back acks
    dbg_req = 1'b1;
    tick();
    push(1); chk("held_ack1", 32'(dbg_ack));
    tick();
    push(1); chk("held_ack2", 32'(dbg_ack));
    dbg_req = 1'b0;
    tick();
    push(0); chk("held_ack_fall", 32'(dbg_ack));

    // debug read bypasses a same-cycle write
    we = 1'b1; wr_addr = 9; wr_data = 32'h13579BDF;
    dbg_req = 1'b1; dbg_addr = 9;
    tick();
    we = 1'b0; dbg_req = 1'b0; rd_addr = {5'd0, 5'd9};
    #1;
    push(32'h13579BDF); chk("dbg_bypass", dbg_data);
    push(32'h13579BDF); chk("x9_p0", rd_data[31:0]);

    // 24-entry, 3-port instance: range limits
    sm_we = 1'b1; sm_wr_addr = 20; wr_data = 32'hCAFEF00D;
    tick();
    sm_wr_addr = 25; wr_data = 32'h11111111;
    sm_rd_addr = {5'd20, 5'd20, 5'd25};
    #1;
    push(0); chk("sm_rd25_bypass", sm_rd_data[31:0]);
    push(32'hCAFEF00D); chk("sm_rd20_p1", sm_rd_data[63:32]);
    push(32'hCAFEF00D); chk("sm_rd20_p2", sm_rd_data[95:64]);
    tick();
    sm_we = 1'b0;
    #1;
    push(0); chk("sm_rd25", sm_rd_data[31:0]);
    push(32'hCAFEF00D); chk("sm_rd20_keep", sm_rd_data[63:32]);

    // reset drops a pending ack, then writes/debug ignored during clear
    dbg_req = 1'b1; dbg_addr = 5;
    tick();
    push(1); chk("ack_before_reset", 32'(dbg_ack));
    reset = 1'b0;
    #1;
    push(0); chk("ack_dropped", 32'(dbg_ack));
    push(0); chk("dbg_data_reset", dbg_data);
    push(1); chk("busy_in_reset", 32'(init_busy));
    #2 reset = 1'b1;
    we = 1'b1; wr_addr = 7; wr_data = 32'hA5A5A5A5;
    rd_addr = {5'd5, 5'd7};
    for (int i = 0; i < 10; i++) begin
      tick();
      push(0); chk("clear_ack", 32'(dbg_ack));
      push(0); chk("clear_rd7", rd_data[31:0]);
      push(0); chk("clear_rd5", rd_data[63:32]);
    end
    reset = 1'b0;
    #2 reset = 1'b1;
    count_init(n, n_sm);
    we = 1'b0; dbg_req = 1'b0;
    push(31); chk("restart_cycles", n);
    #1;
    push(0); chk("x7_dropped", rd_data[31:0]);
    push(0); chk("x5_recleared", rd_data[63:32]);
    push(0); chk("no_ack_after_clear", 32'(dbg_ack));

    we = 1'b1; wr_addr = 7; wr_data = 32'hA5A5A5A5;
    tick();
    we = 1'b0;
    #1;
    push(32'hA5A5A5A5); chk("x7_run_write", rd_data[31:0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
